// File: rtl/aes_round_mix.sv
// aes_round_mix: AES round back-end (ShiftRows, MixColumns, AddRoundKey)
// behind a two-register valid/ready pipeline. MixColumns is skipped on the
// final round. Byte order is FIPS-197 column-major: [127:120]=s(0,0),
// [119:112]=s(1,0), ..., [7:0]=s(3,3).
module aes_round_mix (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic         in_final,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   // GF(2^8) multiply by 2 with the AES reduction polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // MixColumns on a single column {a0,a1,a2,a3}, a0 in the top byte.
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

   // Row r rotates left by r columns: s'(r,c) = s(r,(c+r) mod 4).
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return t;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         t[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
      end
      return t;
   endfunction

   logic         s1_valid;
   logic [127:0] s1_state;
   logic [127:0] s1_key;
   logic         s1_final;
   logic         s2_valid;
   logic [127:0] s2_state;

   logic         s1_adv;
   logic         in_xfer;
   logic [127:0] shifted;
   logic [127:0] mixed;

   // Handshake decode and the combinational datapath feeding both stages.
   always_comb begin
      s1_adv   = s1_valid && (!s2_valid || out_ready);
      in_ready = !s1_valid || s1_adv;
      in_xfer  = in_valid && in_ready;
      shifted  = shift_rows(in_state);
      mixed    = s1_final ? s1_state : mix_columns(s1_state);
   end

   // Valid flags: the only reset state; a stage empties only when it
   // hands off and nothing refills it in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_xfer)
            s1_valid <= 1'b1;
         else if (s1_adv)
            s1_valid <= 1'b0;

         if (s1_adv)
            s2_valid <= 1'b1;
         else if (out_ready)
            s2_valid <= 1'b0;
      end
   end

   // Data registers load on their stage's transfer and otherwise hold.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         s1_state <= shifted;
         s1_key   <= in_key;
         s1_final <= in_final;
      end
      if (s1_adv)
         s2_state <= mixed ^ s1_key;
   end

   // Outputs come straight from stage 2.
   always_comb begin
      out_valid = s2_valid;
      out_state = s2_state;
   end

endmodule

// File: tb/tb_aes_round_mix.sv
// tb_aes_round_mix: directed FIPS-197 vectors, streaming, backpressure,
// random handshake traffic and mid-flight reset for aes_round_mix.
module tb_aes_round_mix;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         in_final;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   int unsigned  n_checks;
   int unsigned  n_errors;
   int unsigned  n_acc;
   logic [127:0] sb[$];

   localparam logic [127:0] FIPS_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] FIPS_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] FIPS_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_FINK = 128'h7445a32768e07e1f9be228c8344beee0;

   aes_round_mix dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_key    (in_key),
      .in_final  (in_final),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // General GF(2^8) multiply, shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference round via a 4x4 byte matrix.
   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin);
      logic [7:0] m[4][4];
      logic [7:0] t[4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = s[127 - 8*(4*c + r) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r][c] = m[r][(c + r) % 4];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            logic [7:0] a[4];
            for (int r = 0; r < 4; r++) a[r] = t[r][c];
            t[0][c] = gmul(a[0], 2) ^ gmul(a[1], 3) ^ a[2] ^ a[3];
            t[1][c] = a[0] ^ gmul(a[1], 2) ^ gmul(a[2], 3) ^ a[3];
            t[2][c] = a[0] ^ a[1] ^ gmul(a[2], 2) ^ gmul(a[3], 3);
            t[3][c] = gmul(a[0], 3) ^ a[1] ^ a[2] ^ gmul(a[3], 2);
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = t[r][c];
      return o ^ k;
   endfunction

   // One clock: observe the handshake just before the edge, score it,
   // then step past the edge.
   task automatic cycle();
      logic acc, cons, stall;
      logic [127:0] held;
      #1;
      acc   = in_valid && in_ready && !rst;
      cons  = out_valid && out_ready && !rst;
      stall = out_valid && !out_ready && !rst;
      held  = out_state;
      if (cons) begin
         check("out_expected", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) check("out_order", out_state, sb.pop_front());
      end
      if (acc) begin
         sb.push_back(ref_round(in_state, in_key, in_final));
         n_acc++;
      end
      @(posedge clk);
      #1;
      if (rst) sb.delete();
      if (stall) begin
         check("stall_valid", 128'(out_valid), 128'(1));
         check("stall_state", out_state, held);
      end
   endtask

   task automatic directed(input string tag, input logic [127:0] s, input logic [127:0] k,
                           input logic fin, input logic [127:0] exp);
      in_state  = s;
      in_key    = k;
      in_final  = fin;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check({tag, "_rdy"}, 128'(in_ready), 128'(1));
      cycle();
      in_valid = 1'b0;
      in_state = '0;
      in_key   = '0;
      check({tag, "_lat1"}, 128'(out_valid), 128'(0));
      cycle();
      check({tag, "_lat2"}, 128'(out_valid), 128'(1));
      check(tag, out_state, exp);
      cycle();
      check({tag, "_done"}, 128'(out_valid), 128'(0));
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cycle();
      check("drain_empty", 128'(sb.size()), 128'(0));
      check("drain_valid", 128'(out_valid), 128'(0));
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      n_acc     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      in_key    = '0;
      in_final  = 1'b0;
      out_ready = 1'b0;
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));

      directed("fips_r1", FIPS_IN, FIPS_KEY, 1'b0, FIPS_R1);
      directed("final_k0", FIPS_IN, '0, 1'b1, FIPS_SR);
      directed("final_key", FIPS_IN, FIPS_KEY, 1'b1, FIPS_FINK);

      // Back-to-back streaming with alternating in_final.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_state = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         in_final = i[0];
         in_valid = 1'b1;
         #1;
         check("stream_rdy", 128'(in_ready), 128'(1));
         cycle();
         if (i >= 1) check("stream_valid", 128'(out_valid), 128'(1));
      end
      in_valid = 1'b0;
      cycle();
      check("stream_tail", 128'(out_valid), 128'(1));
      cycle();
      check("stream_end", 128'(out_valid), 128'(0));
      check("stream_sb", 128'(sb.size()), 128'(0));

      // Backpressure: two states fill the pipe, then input stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = FIPS_IN;
      in_key    = FIPS_KEY;
      in_final  = 1'b0;
      cycle();
      in_final  = 1'b1;
      cycle();
      in_state  = '1;
      #1;
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_head", out_state, FIPS_R1);
      repeat (3) cycle();
      check("bp_hold", out_state, FIPS_R1);
      check("bp_sb", 128'(sb.size()), 128'(2));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 128'(in_ready), 128'(1));
      cycle();
      check("bp_second", out_state, FIPS_FINK);
      cycle();
      check("bp_drained", 128'(out_valid), 128'(0));

      // Random valid/ready traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_state  = {$urandom, $urandom, $urandom, $urandom};
         in_key    = {$urandom, $urandom, $urandom, $urandom};
         in_final  = $urandom_range(0, 1) == 1;
         cycle();
      end
      drain();

      // Reset with two states in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_final  = 1'b0;
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      in_valid  = 1'b0;
      check("mid_full_valid", 128'(out_valid), 128'(1));
      check("mid_full_rdy", 128'(in_ready), 128'(0));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_rst_valid", 128'(out_valid), 128'(0));
      check("mid_rst_rdy", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      repeat (4) begin
         cycle();
         check("mid_no_ghost", 128'(out_valid), 128'(0));
      end
      directed("post_rst", FIPS_IN, FIPS_KEY, 1'b0, FIPS_R1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
